// File: rtl/mrv32_mem_stage.sv
// ---------------------------------------------------------------------------
// mrv32_mem_stage
// Memory-access stage of the RV32I core. It accepts one executed instruction
// at a time and runs the data-memory transaction for loads and stores over a
// req/ack bus. Load data is sign- or zero-extended and store byte enables are
// generated here. Misalignment, illegal encodings and bus timeouts are
// detected. The result is presented to writeback as one valid token, which is
// held until writeback commits it.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   mem_valid / mem_ready    EX handshake (ready only while idle)
//   mem_ren_in, mem_wen_in   load / store request
//   funct3_in                RV32I access size / sign
//   addr_in                  effective address (EX ALU result)
//   store_data_in            rs2 value for stores
//   reg_wen_in, is_lui_in, is_auipc_in, take_branch_in,
//   rd_addr_in, imm_in, pc_in, jal_target_in   pass-through to writeback
//   wb_valid / wb_accept     token to writeback / writeback commit pulse
//   *_out                    latched control/data for writeback
//   load_data_out            extended load result (0 for stores and faults)
//   fault_cause              0 none, 1 misaligned, 2 bus timeout, 3 illegal
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata   data-memory bus
// ---------------------------------------------------------------------------
module mrv32_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255  // 1..1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_ren_in,
  input  logic        mem_wen_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic        reg_wen_in,
  input  logic        is_lui_in,
  input  logic        is_auipc_in,
  input  logic        take_branch_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] jal_target_in,
  output logic        wb_valid,
  output logic        reg_wen_out,
  output logic        mem_ren_out,
  output logic        is_lui_out,
  output logic        is_auipc_out,
  output logic        take_branch_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] imm_out,
  output logic [31:0] pc_out,
  output logic [31:0] jal_target_out,
  output logic [31:0] load_data_out,
  output logic [1:0]  fault_cause,
  input  logic        wb_accept,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_MISALGN = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd3;

  // Counter value on the last allowed request cycle.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [9:0]  wait_cnt;
  logic [2:0]  funct3_q;

  logic        accept;
  logic        is_mem;
  logic [1:0]  cause_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        bus_ack;
  logic        bus_timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  assign mem_ready   = (state == S_IDLE);
  assign wb_valid    = (state == S_RESP);
  assign dmem_req    = (state == S_BUS);
  assign accept      = mem_ready && mem_valid;
  assign is_mem      = mem_ren_in || mem_wen_in;
  // An ack on the timeout cycle still counts as a completed transfer.
  assign bus_ack     = dmem_req && dmem_ack;
  assign bus_timeout = dmem_req && !dmem_ack && (wait_cnt == CNT_LAST);

  // Fault classification and store formatting on the incoming instruction.
  // NOTE: every variable written in a combinational block gets a default at
  // the top so that no path leaves it unassigned and infers a latch.
  always_comb begin
    cause_in = FAULT_NONE;
    be_in    = 4'b0000;
    wdata_in = 32'h0;
    if (is_mem) begin
      if ((mem_ren_in && mem_wen_in) ||
          (mem_ren_in && (funct3_in == 3'd3 || funct3_in == 3'd6 || funct3_in == 3'd7)) ||
          (mem_wen_in && funct3_in > 3'd2)) begin
        cause_in = FAULT_ILLEGAL;
      end else if ((funct3_in[1:0] == 2'b01 && addr_in[0]) ||
                   (funct3_in[1:0] == 2'b10 && addr_in[1:0] != 2'b00)) begin
        cause_in = FAULT_MISALGN;
      end
    end
    case (funct3_in[1:0])
      2'b00: begin
        be_in    = 4'b0001 << addr_in[1:0];
        wdata_in = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        be_in    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data_in[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data_in;
      end
    endcase
    if (!mem_wen_in) wdata_in = 32'h0;
  end

  // Lane selection and extension of the returned word, using the latched
  // address offset and funct3.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (alu_result_out[1:0])
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = alu_result_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (mem_valid) state_next = (is_mem && cause_in == FAULT_NONE) ? S_BUS : S_RESP;
      S_BUS:  if (bus_ack || bus_timeout) state_next = S_RESP;
      S_RESP: if (wb_accept) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt        <= '0;
      funct3_q        <= '0;
      reg_wen_out     <= 1'b0;
      mem_ren_out     <= 1'b0;
      is_lui_out      <= 1'b0;
      is_auipc_out    <= 1'b0;
      take_branch_out <= 1'b0;
      rd_addr_out     <= '0;
      alu_result_out  <= '0;
      imm_out         <= '0;
      pc_out          <= '0;
      jal_target_out  <= '0;
      load_data_out   <= '0;
      fault_cause     <= FAULT_NONE;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_be         <= '0;
      dmem_wdata      <= '0;
    end else if (accept) begin
      wait_cnt        <= '0;
      funct3_q        <= funct3_in;
      reg_wen_out     <= reg_wen_in && (cause_in == FAULT_NONE);
      mem_ren_out     <= mem_ren_in;
      is_lui_out      <= is_lui_in;
      is_auipc_out    <= is_auipc_in;
      take_branch_out <= take_branch_in;
      rd_addr_out     <= rd_addr_in;
      alu_result_out  <= addr_in;
      imm_out         <= imm_in;
      pc_out          <= pc_in;
      jal_target_out  <= jal_target_in;
      load_data_out   <= '0;
      fault_cause     <= cause_in;
      dmem_we         <= mem_wen_in;
      dmem_addr       <= {addr_in[31:2], 2'b00};
      dmem_be         <= be_in;
      dmem_wdata      <= wdata_in;
    end else if (bus_ack) begin
      // A bus transfer only starts for a fault-free load or store, so the
      // latched read flag alone distinguishes the two.
      if (mem_ren_out) load_data_out <= ld_fmt;
    end else if (bus_timeout) begin
      fault_cause <= FAULT_TIMEOUT;
      reg_wen_out <= 1'b0;
    end else if (dmem_req) begin
      wait_cnt <= wait_cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_mrv32_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mrv32_mem_stage
// Directed and randomized stimulus for mrv32_mem_stage against a reference
// model that derives faults, byte enables, write data and load results with
// plain arithmetic. Inputs are driven and outputs sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_mrv32_mem_stage;

  localparam int TMO = 4;

  typedef struct {
    logic        ren, wen;
    logic [2:0]  f3;
    logic [31:0] addr, sd, imm, pc, jal;
    logic        reg_wen, lui, auipc, br;
    logic [4:0]  rd;
  } op_t;

  logic        clk, rst;
  logic        mem_valid, mem_ready, mem_ren_in, mem_wen_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in;
  logic        reg_wen_in, is_lui_in, is_auipc_in, take_branch_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] imm_in, pc_in, jal_target_in;
  logic        wb_valid, reg_wen_out, mem_ren_out, is_lui_out, is_auipc_out, take_branch_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] alu_result_out, imm_out, pc_out, jal_target_out, load_data_out;
  logic [1:0]  fault_cause;
  logic        wb_accept;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mrv32_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_ren_in(mem_ren_in), .mem_wen_in(mem_wen_in), .funct3_in(funct3_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .reg_wen_in(reg_wen_in), .is_lui_in(is_lui_in), .is_auipc_in(is_auipc_in),
    .take_branch_in(take_branch_in), .rd_addr_in(rd_addr_in), .imm_in(imm_in),
    .pc_in(pc_in), .jal_target_in(jal_target_in),
    .wb_valid(wb_valid), .reg_wen_out(reg_wen_out), .mem_ren_out(mem_ren_out),
    .is_lui_out(is_lui_out), .is_auipc_out(is_auipc_out),
    .take_branch_out(take_branch_out), .rd_addr_out(rd_addr_out),
    .alu_result_out(alu_result_out), .imm_out(imm_out), .pc_out(pc_out),
    .jal_target_out(jal_target_out), .load_data_out(load_data_out),
    .fault_cause(fault_cause), .wb_accept(wb_accept),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input op_t op);
    mem_ren_in     = op.ren;
    mem_wen_in     = op.wen;
    funct3_in      = op.f3;
    addr_in        = op.addr;
    store_data_in  = op.sd;
    reg_wen_in     = op.reg_wen;
    is_lui_in      = op.lui;
    is_auipc_in    = op.auipc;
    take_branch_in = op.br;
    rd_addr_in     = op.rd;
    imm_in         = op.imm;
    pc_in          = op.pc;
    jal_target_in  = op.jal;
  endtask

  // Scramble inputs after acceptance so that only latched values can match.
  task automatic scramble_inputs();
    mem_ren_in     = 1'($urandom);
    mem_wen_in     = 1'($urandom);
    funct3_in      = 3'($urandom);
    addr_in        = $urandom;
    store_data_in  = $urandom;
    reg_wen_in     = 1'($urandom);
    is_lui_in      = 1'($urandom);
    is_auipc_in    = 1'($urandom);
    take_branch_in = 1'($urandom);
    rd_addr_in     = 5'($urandom);
    imm_in         = $urandom;
    pc_in          = $urandom;
    jal_target_in  = $urandom;
  endtask

  function automatic op_t make_op(input logic ren, input logic wen, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] sd);
    op_t op;
    op.ren = ren; op.wen = wen; op.f3 = f3; op.addr = addr; op.sd = sd;
    op.reg_wen = ren | ~wen; op.lui = 1'b0; op.auipc = 1'b0; op.br = 1'b0;
    op.rd = 5'd5; op.imm = 32'h0000_0ABC; op.pc = 32'h0000_0400; op.jal = 32'h0000_0800;
    return op;
  endfunction

  // ack_delay: cycles of wait before ack (-1 = never ack).
  task automatic run_op(input op_t op, input int ack_delay, input logic [31:0] rdata,
                        input bit late_ack);
    int          off, size, exp_req, req_cycles, hold;
    logic [1:0]  exp_cause;
    logic        exp_bus, exp_rw;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_ld, v;

    off  = int'(op.addr % 4);
    size = int'(op.f3 % 4);
    exp_cause = 2'd0;
    if (op.ren || op.wen) begin
      if ((op.ren && op.wen) || (op.ren && (op.f3 == 3 || op.f3 >= 6)) || (op.wen && op.f3 > 2))
        exp_cause = 2'd3;
      else if ((size == 1 && off % 2 != 0) || (size == 2 && off != 0))
        exp_cause = 2'd1;
    end
    exp_bus = (op.ren || op.wen) && exp_cause == 2'd0;

    exp_be = 4'd15;
    exp_wd = op.sd;
    if (size == 0) begin
      exp_be = 4'(1 << off);
      exp_wd = (op.sd & 32'hFF) * 32'h0101_0101;
    end else if (size == 1) begin
      exp_be = 4'(3 << off);
      exp_wd = (op.sd & 32'hFFFF) * 32'h0001_0001;
    end

    exp_ld = 32'h0;
    if (exp_bus && ack_delay < 0) begin
      exp_cause = 2'd2;
    end else if (exp_bus && op.ren) begin
      if (size == 0) begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (!op.f3[2] && v >= 128) v = v - 256;
      end else if (size == 1) begin
        v = (rdata >> (8 * off)) & 32'hFFFF;
        if (!op.f3[2] && v >= 32768) v = v - 65536;
      end else begin
        v = rdata;
      end
      exp_ld = v;
    end
    exp_rw  = op.reg_wen && exp_cause == 2'd0;
    exp_req = !exp_bus ? 0 : (ack_delay < 0 ? TMO : ack_delay + 1);

    @(negedge clk);
    check("ready_before", mem_ready, 1);
    drive_op(op);
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    scramble_inputs();

    req_cycles = 0;
    for (int c = 0; c < TMO + 2; c++) begin
      if (!dmem_req) break;
      req_cycles++;
      check("ready_bus", mem_ready, 0);
      check("wbv_bus", wb_valid, 0);
      check("dmem_addr", dmem_addr, {op.addr[31:2], 2'b00});
      check("dmem_we", dmem_we, op.wen);
      if (op.wen) begin
        check("dmem_be", dmem_be, exp_be);
        check("dmem_wdata", dmem_wdata, exp_wd);
      end
      wb_accept = 1'($urandom);
      if (c == ack_delay) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
      dmem_ack   = 1'b0;
      wb_accept  = 1'b0;
      dmem_rdata = $urandom;
      if (c == ack_delay) break;
    end
    check("req_cycles", req_cycles, exp_req);
    check("req_low", dmem_req, 0);

    check("wb_valid", wb_valid, 1);
    check("fault", fault_cause, exp_cause);
    check("reg_wen", reg_wen_out, exp_rw);
    check("load_data", load_data_out, exp_ld);
    check("alu_result", alu_result_out, op.addr);
    check("mem_ren", mem_ren_out, op.ren);
    check("rd", rd_addr_out, op.rd);
    check("pc", pc_out, op.pc);
    check("imm", imm_out, op.imm);
    check("jal", jal_target_out, op.jal);
    check("flags", {is_lui_out, is_auipc_out, take_branch_out}, {op.lui, op.auipc, op.br});
    check("ready_resp", mem_ready, 0);

    if (late_ack) begin
      dmem_ack   = 1'b1;
      dmem_rdata = $urandom;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("late_ack_wbv", wb_valid, 1);
      check("late_ack_fault", fault_cause, exp_cause);
      check("late_ack_ld", load_data_out, exp_ld);
      check("late_ack_req", dmem_req, 0);
    end

    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_wbv", wb_valid, 1);
    end

    // Offer a new instruction in the commit cycle: it must not be taken.
    wb_accept = 1'b1;
    mem_valid = 1'b1;
    mem_ren_in = 1'b0;
    mem_wen_in = 1'b0;
    @(negedge clk);
    wb_accept = 1'b0;
    mem_valid = 1'b0;
    check("wbv_after_accept", wb_valid, 0);
    check("ready_after_accept", mem_ready, 1);
  endtask

  op_t op;

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0; wb_accept = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    op = make_op(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive_op(op);
    repeat (2) @(negedge clk);
    check("rst_wbv", wb_valid, 0);
    check("rst_req", dmem_req, 0);
    check("rst_ready", mem_ready, 1);
    check("rst_alu", alu_result_out, 0);
    check("rst_fault", fault_cause, 0);
    check("rst_be", dmem_be, 0);
    rst = 1'b0;

    // Non-memory op.
    op = make_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0);
    op.reg_wen = 1'b1; op.lui = 1'b1; op.br = 1'b1;
    run_op(op, 0, 32'h0, 1'b0);
    // LB / LBU at offset 3 with two wait cycles.
    run_op(make_op(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0), 2, 32'h80FF_FF7F, 1'b0);
    run_op(make_op(1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'h0), 2, 32'h80FF_FF7F, 1'b0);
    // SH at offset 2, zero-wait ack.
    run_op(make_op(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'hABCD_1234), 0, 32'h0, 1'b0);
    // Misaligned LW and illegal load funct3.
    run_op(make_op(1'b1, 1'b0, 3'd2, 32'h0000_3001, 32'h0), 0, 32'h0, 1'b0);
    run_op(make_op(1'b1, 1'b0, 3'd3, 32'h0000_3001, 32'h0), 0, 32'h0, 1'b0);
    // Load and store together are illegal.
    run_op(make_op(1'b1, 1'b1, 3'd2, 32'h0000_3000, 32'h0), 0, 32'h0, 1'b0);
    // Timeout followed by a late ack.
    run_op(make_op(1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'h0), -1, 32'h0, 1'b1);

    // Reset in the middle of a bus transaction.
    @(negedge clk);
    drive_op(make_op(1'b1, 1'b0, 3'd2, 32'h0000_5000, 32'h0));
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    check("midbus_req", dmem_req, 1);
    rst = 1'b1;
    #1;
    check("rst_async_req", dmem_req, 0);
    check("rst_async_wbv", wb_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", mem_ready, 1);
    check("post_rst_alu", alu_result_out, 0);
    run_op(make_op(1'b1, 1'b0, 3'd2, 32'h0000_6004, 32'h0), 1, 32'hCAFE_F00D, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      int kind, dly;
      kind = $urandom_range(0, 9);
      op.ren = (kind >= 2 && kind <= 5) || kind == 9;
      op.wen = kind >= 6;
      if ($urandom_range(0, 3) == 0) op.f3 = 3'($urandom);
      else if (op.wen)               op.f3 = 3'($urandom_range(0, 2));
      else begin
        op.f3 = 3'($urandom_range(0, 4));
        if (op.f3 == 3'd3) op.f3 = 3'd5;
      end
      op.addr = $urandom;
      if ($urandom_range(0, 1) == 0)
        op.addr = op.addr & ~((32'd1 << op.f3[1:0]) - 32'd1);
      op.sd = $urandom; op.imm = $urandom; op.pc = $urandom; op.jal = $urandom;
      op.reg_wen = 1'($urandom); op.lui = 1'($urandom); op.auipc = 1'($urandom);
      op.br = 1'($urandom); op.rd = 5'($urandom);
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO - 2));
      run_op(op, dly, $urandom, (dly < 0) || ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
